ics0_addr_gen: RTL
==================

Name: ics0_addr_gen

Overview:
Fetch address generator for the instruction cache. It sits directly upstream of the stage-1 restart block.
- Produces the current read address with valid/ready handshaking.
- Advances sequentially on each accepted address and accepts redirect (branch/jump) targets.
- Reports the last accepted address and its valid flag. The restart stage captures these when a miss begins and replays them afterwards.

Parameters:
ADDR_WIDTH, 16, width of the read address.
INCR, 1, sequential step added to the address per accepted fetch.
RESET_ADDR, 16'h0000, address loaded at reset.
BURST_LEN, 8, accepted fetches allowed per start/redirect (used only when ICS0_BURST_LIMIT_EN is defined; must be >= 1).

Ports:
clk  input  1  clock, rising edge.
arst_n  input  1  asynchronous active-low reset.
i_halt  input  1  global stall; freezes all state.
i_start  input  1  pulse; begin issuing addresses.
i_stop  input  1  pulse; stop issuing addresses.
i_redirect_addr  input  ADDR_WIDTH  redirect target.
i_redirect_valid  input  1  redirect request.
o_redirect_ready  output  1  redirect accepted this cycle; equals ~i_halt.
o_r_addr  output  ADDR_WIDTH  current read address; drives the restart stage's current-address input.
o_r_addr_valid  output  1  current address valid.
i_r_addr_ready  input  1  downstream ready; driven by the restart stage's current-address ready.
o_prev_r_addr  output  ADDR_WIDTH  last accepted address.
o_prev_r_addr_valid  output  1  at least one address accepted since reset.

Behaviour:
- Reset (asynchronous, arst_n=0):
  - state=STOPPED, r_addr=RESET_ADDR.
  - o_r_addr_valid=0, o_prev_r_addr=0, o_prev_r_addr_valid=0, burst counter=0.
- States:
  - STOPPED: o_r_addr_valid=0.
  - RUNNING: o_r_addr_valid=~i_halt.
- Output timing:
  - o_r_addr is registered (r_addr).
  - o_r_addr_valid is registered state gated combinationally by ~i_halt.
- Handshake definitions:
  - fire = o_r_addr_valid & i_r_addr_ready.
  - redir = i_redirect_valid & ~i_halt.
- Transitions (evaluated only when i_halt=0):
  - STOPPED -> RUNNING on i_start. Valid asserts the cycle after i_start.
  - RUNNING -> STOPPED on i_stop. A fire in the same cycle as i_stop still completes.
  - i_start and i_stop in the same cycle: stop wins.
- Address update priority:
  - redir: r_addr <= i_redirect_addr. This applies in either state; state is unchanged.
  - else fire: r_addr <= (r_addr + INCR) mod 2^ADDR_WIDTH. Wrap-around is silent, e.g. 16'hFFFF -> 16'h0000 with INCR=1.
  - else: r_addr holds.
- Address stability: o_r_addr stays stable while valid & ~ready. The only exception is a redirect, which replaces the unaccepted address on the next cycle.
- Previous-address tracking:
  - On fire: o_prev_r_addr <= r_addr (the accepted address, even if a redirect hits the same cycle) and o_prev_r_addr_valid <= 1.
  - Otherwise both hold.
- Halt:
  - While i_halt=1, all registers hold.
  - o_r_addr_valid=0 and o_redirect_ready=0.
  - A redirect source must hold i_redirect_valid until o_redirect_ready.
- Reset mid-operation: everything returns to reset values immediately. Any unaccepted address is lost.

Optional Feature:
ICS0_BURST_LIMIT_EN:
- Defined:
  - A counter of width $clog2(BURST_LEN)+1 counts fires since the last i_start or redirect.
  - A fire while count==BURST_LEN-1 forces RUNNING -> STOPPED next cycle and clears the count.
  - i_start and accepted redirects clear the count. A redirect coinciding with the final fire clears the count and the block still stops.
- Undefined: no counter; the block runs until i_stop.

Test Plan:
- Reset, i_start at cycle 2, ready=1 held -> valid from cycle 3; o_r_addr 0,1,2,3 on consecutive cycles; o_prev_r_addr lags by one accepted address with o_prev_r_addr_valid=1 after the first fire.
- Running at address 0x0010, ready=0 for 3 cycles -> o_r_addr stays 0x0010 and valid stays 1; after ready=1, the next address is 0x0011.
- Redirect to 0x1234 in the same cycle as a fire of 0x0020 -> o_prev_r_addr=0x0020; next o_r_addr=0x1234, then 0x1235.
- Start at 0xFFFE, ready=1 -> 0xFFFE, 0xFFFF, 0x0000; halt asserted for 2 cycles mid-stream -> valid=0, redirect_ready=0, no address advance, and the stream resumes exactly where it paused.
- i_start and i_stop together while STOPPED -> stays STOPPED; i_stop during a fire -> that fire is counted and valid drops the next cycle.
- With ICS0_BURST_LIMIT_EN and BURST_LEN=4, start at 0x0100 -> exactly 0x0100..0x0103 accepted, then valid=0 until the next i_start.

Source files
------------

// File: rtl/ics0_addr_gen.sv
// ============================================================================
//  Module      : ics0_addr_gen
//  Description : Instruction-cache fetch address generator. Issues sequential
//                read addresses with a valid/ready handshake, accepts redirect
//                targets, and reports the last accepted address for replay by
//                the downstream restart stage.
//                Optional burst limit: define ICS0_BURST_LIMIT_EN to stop
//                automatically after BURST_LEN accepted fetches per
//                start/redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ics0_addr_gen #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    INCR       = 1,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter int                    BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_halt,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [ADDR_WIDTH-1:0] i_redirect_addr,
    input  logic                  i_redirect_valid,
    output logic                  o_redirect_ready,
    output logic [ADDR_WIDTH-1:0] o_r_addr,
    output logic                  o_r_addr_valid,
    input  logic                  i_r_addr_ready,
    output logic [ADDR_WIDTH-1:0] o_prev_r_addr,
    output logic                  o_prev_r_addr_valid
);

    localparam logic [ADDR_WIDTH-1:0] c_incr = ADDR_WIDTH'(INCR);

    typedef enum logic [0:0] {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   r_addr_q;
    logic [ADDR_WIDTH-1:0]   r_addr_d;
    logic [ADDR_WIDTH-1:0]   prev_addr_q;
    logic [ADDR_WIDTH-1:0]   prev_addr_d;
    logic                    prev_valid_q;
    logic                    prev_valid_d;

    logic                    w_fire;
    logic                    w_redir;
    logic                    w_burst_done;

    // Valid is the registered run state, suppressed combinationally by halt
    assign o_r_addr_valid   = (state_q == ST_RUNNING) & ~i_halt;
    assign o_redirect_ready = ~i_halt;
    assign o_r_addr         = r_addr_q;
    assign o_prev_r_addr    = prev_addr_q;
    assign o_prev_r_addr_valid = prev_valid_q;

    assign w_fire  = o_r_addr_valid & i_r_addr_ready;
    assign w_redir = i_redirect_valid & ~i_halt;

`ifdef ICS0_BURST_LIMIT_EN
    localparam int              c_cnt_w      = $clog2(BURST_LEN) + 1;
    localparam logic [c_cnt_w-1:0] c_burst_last = c_cnt_w'(BURST_LEN - 1);

    logic [c_cnt_w-1:0] burst_cnt_q;
    logic [c_cnt_w-1:0] burst_cnt_d;

    // The final fire of a burst stops the stream, even if a redirect coincides
    assign w_burst_done = w_fire & (burst_cnt_q == c_burst_last);

    // Count accepted fetches; a start or accepted redirect opens a new burst
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (i_start | w_redir) begin
            burst_cnt_d = '0;
        end else if (w_fire) begin
            burst_cnt_d = w_burst_done ? '0 : burst_cnt_q + c_cnt_w'(1);
        end
    end

    // Burst counter register, frozen during halt
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            burst_cnt_q <= '0;
        end else if (!i_halt) begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    logic w_unused_burst;
    assign w_unused_burst = (BURST_LEN > 0);
    assign w_burst_done   = 1'b0;
`endif

    // Run/stop state machine; stop dominates a simultaneous start
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_STOPPED;
        end else if (!i_halt) begin
            case (state_q)
                ST_STOPPED: begin
                    if (i_start && !i_stop) begin
                        state_q <= ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (i_stop || w_burst_done) begin
                        state_q <= ST_STOPPED;
                    end
                end
                default: state_q <= ST_STOPPED;
            endcase
        end
    end

    // Next address: redirect beats sequential advance; prev captures the
    // address actually accepted, independent of any coincident redirect
    always_comb begin
        r_addr_d     = r_addr_q;
        prev_addr_d  = prev_addr_q;
        prev_valid_d = prev_valid_q;
        if (w_redir) begin
            r_addr_d = i_redirect_addr;
        end else if (w_fire) begin
            r_addr_d = r_addr_q + c_incr;
        end
        if (w_fire) begin
            prev_addr_d  = r_addr_q;
            prev_valid_d = 1'b1;
        end
    end

    // Address registers, frozen during halt
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_addr_q     <= RESET_ADDR;
            prev_addr_q  <= '0;
            prev_valid_q <= 1'b0;
        end else if (!i_halt) begin
            r_addr_q     <= r_addr_d;
            prev_addr_q  <= prev_addr_d;
            prev_valid_q <= prev_valid_d;
        end
    end

endmodule

`default_nettype wire
